psum_accum_wb: RTL and testbench
================================

// Module: psum_accum_wb
// PURPOSE
//  Parametrised full-channel accumulate-and-writeback stage for the conv engine. Takes
//  per-position LANES-wide partial-sum vectors from the CMAC array, one vector per channel
//  group, and reduces the lanes. Accumulates into a per-row sum buffer across all
//  ceil(i_channel/LANES) groups, then streams the finished row to the DMA p0 write port.
// PARAMETERS
//  LANES      16   parallel CMAC lanes per psum vector (power of 2, 2..32)
//  DW         16   lane / writeback data width (signed two's complement)
//  ACC_W      24   internal accumulator width (>= DW+clog2(LANES))
//  SUM_DEPTH  128  sum buffer entries = max supported o_side
// PORTS
//  clk               in   1           clock
//  rst               in   1           async reset, active high
//  cfg_valid         in   1           layer start; sampled in IDLE
//  i_channel         in   16          input channels (>=1)
//  o_channel         in   16          output channels (>=1)
//  o_side            in   8           outputs per row (1..SUM_DEPTH)
//  result_start_addr in   30          writeback base address
//  psum_valid        in   1           psum vector valid
//  psum_data         in   LANES*DW    lane i = bits [i*DW+:DW]
//  psum_ready        out  1           accept when valid&ready
//  wb_en             out  1           to DMA p0 writes_en
//  wb_addr           out  30          row base address
//  wb_re             in   1           DMA p0 ib_re: requests one word
//  wb_data           out  DW          saturated sum word
//  wb_valid          out  1           wb_data valid (1 cycle per word)
//  engine_ready      out  1           layer done, held until cfg_valid low
// BEHAVIOUR
//  Reset: all outputs 0; sum buffer, counters and state cleared. rst mid-operation
//  aborts immediately and all state returns to IDLE.
//  groups G = ceil(i_channel/LANES); rows R = o_side*o_channel (16x8 -> 24-bit count).
//  FSM IDLE->ACCUM (cfg_valid) ->DRAIN (last vector of last group accepted)
//   ->WB (pipe empty) ->ACCUM (row done, more rows) | DONE (last row written).
//  DONE->IDLE when cfg_valid==0.
//  ACCUM: psum_ready=1. Vectors arrive position-major: pos 0..o_side-1 for group 0,
//   then group 1, and so on. Counters pos_idx and grp_idx wrap accordingly.
//  Last group lane mask: lanes >= i_channel-(G-1)*LANES forced to 0.
//  Lane reduction: sign-extend to ACC_W, combinational tree, 1 register stage. sum[pos] is
//   updated the cycle after acceptance, so accept-to-update latency = 2.
//  Group 0 overwrites sum[pos]; later groups add to it.
//  RMW hazard (o_side==1, back-to-back groups): forward the pending register value
//   instead of the stale buffer read; no bubble is inserted.
//  ACC_W add wraps silently; saturation happens only on output.
//  DRAIN: psum_ready=0 for 1 cycle until the last update lands.
//  WB: wb_en=1, wb_addr = result_start_addr + row*o_side (held for the whole row).
//   Each wb_re cycle -> next cycle wb_valid=1, wb_data = sat_DW(sum[wb_idx]); the entry
//   is zeroed on read and wb_idx increments. wb_re is ignored after o_side words.
//   After the final word: wb_en=0 the next cycle, row+1.
//  Saturation: >2^(DW-1)-1 -> 0x7FFF; <-2^(DW-1) -> 0x8000 (DW=16).
//  Simultaneous psum_valid in WB/DRAIN/DONE: psum_ready=0, nothing accepted.
//  engine_ready=1 only in DONE.
// CONFIGURATION
//  PSUM_BIAS_EN defined: extra ports bias_valid(in,1) and bias(in,DW), sampled with
//   cfg_valid for the first output channel and again at every o_side-row boundary for
//   later channels. Group 0 writes bias+reduced value instead of the reduced value alone.
//  PSUM_BIAS_EN undefined: no bias ports; group 0 overwrites with the reduced value only.
// TESTING
//  T1 LANES=16, i_ch=16, o_side=4, o_ch=1, all lanes=1 x4 -> 4 wb words =16, addr=base,
//     then engine_ready=1.
//  T2 i_ch=20 (G=2), lanes 4..15 of group 1 =5, others 1 -> masked: each word =16+4=20.
//  T3 o_side=1, G=3, back-to-back vectors sum 7,8,9 -> word 24 (forwarding exercised).
//  T4 lanes=0x7FFF x16 -> word 0x7FFF; lanes=0x8000 x16 -> word 0x8000.
//  T5 wb_re with gaps (1 every 3 cycles) -> wb_valid 1 cycle after each re; exactly
//     o_side words; 2nd row addr=base+o_side.
//  T6 rst asserted mid-WB -> all outputs 0 next edge; new cfg_valid after release
//     gives clean (zeroed) sums.

Source files
------------

// File: rtl/psum_accum_wb.sv
// Accumulate-and-writeback stage: lane-reduces CMAC psum vectors over all channel groups
// into a per-row sum buffer and streams saturated words to the DMA. Optional: PSUM_BIAS_EN.
module psum_accum_wb #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned SUM_DEPTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [15:0]           i_channel,
    input  logic [15:0]           o_channel,
    input  logic [7:0]            o_side,
    input  logic [29:0]           result_start_addr,
    input  logic                  psum_valid,
    input  logic [LANES*DW-1:0]   psum_data,
    output logic                  psum_ready,
    output logic                  wb_en,
    output logic [29:0]           wb_addr,
    input  logic                  wb_re,
    output logic [DW-1:0]         wb_data,
    output logic                  wb_valid,
    output logic                  engine_ready
`ifdef PSUM_BIAS_EN
    ,
    input  logic                  bias_valid,
    input  logic [DW-1:0]         bias
`endif
);

    localparam int unsigned AW  = $clog2(SUM_DEPTH);
    localparam int unsigned LW  = $clog2(LANES);
    localparam int unsigned LCW = LW + 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_WB, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         pos_q, pos_d, oside_q, oside_d, wb_idx_q, wb_idx_d;
    logic [15:0]        grp_q, grp_d, grp_last_q, grp_last_d;
    logic [LCW-1:0]     last_lanes_q, last_lanes_d;
    logic [23:0]        row_q, row_d, rows_q, rows_d;
    logic [29:0]        row_addr_q, row_addr_d;
    logic               p_vld_q, p_vld_d, p_first_q, p_first_d;
    logic [AW-1:0]      p_pos_q, p_pos_d;
    logic [ACC_W-1:0]   p_red_q, p_red_d, p_old_q, p_old_d;
    logic               psum_ready_q, psum_ready_d, wb_en_q, wb_en_d;
    logic               wb_valid_q, wb_valid_d, engine_ready_q, engine_ready_d;
    logic [29:0]        wb_addr_q, wb_addr_d;
    logic [DW-1:0]      wb_data_q, wb_data_d;
    logic [ACC_W-1:0]   sum_q [SUM_DEPTH];
    logic               sum_we;
    logic [AW-1:0]      sum_waddr;
    logic [ACC_W-1:0]   sum_wdata, upd, red_c, bias_ext;
    logic [15:0]        ich_m1;
    logic               accept;
`ifdef PSUM_BIAS_EN
    logic [DW-1:0]      bias_q, bias_d;
    logic [7:0]         ch_row_q, ch_row_d;
    assign bias_ext = ACC_W'($signed(bias_q));
`else
    assign bias_ext = '0;
`endif

    assign ich_m1       = i_channel - 16'd1;
    assign accept       = psum_valid && psum_ready_q;
    assign upd          = p_first_q ? (p_red_q + bias_ext) : (p_old_q + p_red_q);
    assign psum_ready   = psum_ready_q;
    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign wb_valid     = wb_valid_q;
    assign engine_ready = engine_ready_q;

    function automatic logic [DW-1:0] sat(input logic [ACC_W-1:0] a);
        if ((&a[ACC_W-1:DW-1]) || !(|a[ACC_W-1:DW-1])) return a[DW-1:0];
        else if (a[ACC_W-1])                           return {1'b1, {(DW-1){1'b0}}};
        else                                           return {1'b0, {(DW-1){1'b1}}};
    endfunction

    // Lane reduction; lanes past i_channel in the last group are masked off
    always_comb begin
        red_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((grp_q != grp_last_q) || (LCW'(i) < last_lanes_q))
                red_c = red_c + ACC_W'($signed(psum_data[i*DW +: DW]));
        end
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        grp_d        = grp_q;
        oside_d      = oside_q;
        grp_last_d   = grp_last_q;
        last_lanes_d = last_lanes_q;
        rows_d       = rows_q;
        row_d        = row_q;
        row_addr_d   = row_addr_q;
        wb_idx_d     = wb_idx_q;
        p_vld_d      = 1'b0;
        p_first_d    = p_first_q;
        p_pos_d      = p_pos_q;
        p_red_d      = p_red_q;
        p_old_d      = p_old_q;
        wb_data_d    = wb_data_q;
        wb_valid_d   = 1'b0;
        wb_addr_d    = wb_addr_q;
        sum_we       = p_vld_q;
        sum_waddr    = p_pos_q;
        sum_wdata    = upd;
`ifdef PSUM_BIAS_EN
        bias_d       = bias_q;
        ch_row_d     = ch_row_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    oside_d      = o_side;
                    grp_last_d   = ich_m1 >> LW;
                    last_lanes_d = LCW'({1'b0, ich_m1[LW-1:0]}) + LCW'(1);
                    rows_d       = 24'(o_side) * 24'(o_channel);
                    row_d        = '0;
                    pos_d        = '0;
                    grp_d        = '0;
                    row_addr_d   = result_start_addr;
`ifdef PSUM_BIAS_EN
                    ch_row_d     = '0;
                    bias_d       = bias_valid ? bias : '0;
`endif
                    state_d      = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    p_vld_d   = 1'b1;
                    p_pos_d   = pos_q[AW-1:0];
                    p_first_d = (grp_q == 16'd0);
                    p_red_d   = red_c;
                    // Same position still in flight: take the pending value, not the stale entry
                    p_old_d   = (p_vld_q && (p_pos_q == pos_q[AW-1:0])) ? upd : sum_q[pos_q[AW-1:0]];
                    if (pos_q == oside_q - 8'd1) begin
                        pos_d = '0;
                        if (grp_q == grp_last_q) state_d = S_DRAIN;
                        else                     grp_d   = grp_q + 16'd1;
                    end else begin
                        pos_d = pos_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                wb_idx_d = '0;
                state_d  = S_WB;
            end
            S_WB: begin
                if (wb_re && (wb_idx_q < oside_q)) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = sat(sum_q[wb_idx_q[AW-1:0]]);
                    sum_we     = 1'b1;
                    sum_waddr  = wb_idx_q[AW-1:0];
                    sum_wdata  = '0;
                    wb_idx_d   = wb_idx_q + 8'd1;
                    if (wb_idx_q == oside_q - 8'd1) begin
                        row_d      = row_q + 24'd1;
                        row_addr_d = row_addr_q + 30'(oside_q);
                        pos_d      = '0;
                        grp_d      = '0;
`ifdef PSUM_BIAS_EN
                        if (ch_row_q == oside_q - 8'd1) begin
                            ch_row_d = '0;
                            bias_d   = bias_valid ? bias : '0;
                        end else begin
                            ch_row_d = ch_row_q + 8'd1;
                        end
`endif
                        state_d    = (row_q + 24'd1 == rows_q) ? S_DONE : S_ACCUM;
                    end
                end
            end
            S_DONE: begin
                if (!cfg_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        psum_ready_d   = (state_d == S_ACCUM);
        wb_en_d        = (state_d == S_WB);
        engine_ready_d = (state_d == S_DONE);
        if (state_d == S_WB) wb_addr_d = row_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SUM_DEPTH; i++) sum_q[i] <= '0;
        end else if (sum_we) begin
            sum_q[sum_waddr] <= sum_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pos_q          <= '0;
            grp_q          <= '0;
            oside_q        <= '0;
            grp_last_q     <= '0;
            last_lanes_q   <= '0;
            rows_q         <= '0;
            row_q          <= '0;
            row_addr_q     <= '0;
            wb_idx_q       <= '0;
            p_vld_q        <= 1'b0;
            p_first_q      <= 1'b0;
            p_pos_q        <= '0;
            p_red_q        <= '0;
            p_old_q        <= '0;
            psum_ready_q   <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            wb_valid_q     <= 1'b0;
            engine_ready_q <= 1'b0;
`ifdef PSUM_BIAS_EN
            bias_q         <= '0;
            ch_row_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            grp_q          <= grp_d;
            oside_q        <= oside_d;
            grp_last_q     <= grp_last_d;
            last_lanes_q   <= last_lanes_d;
            rows_q         <= rows_d;
            row_q          <= row_d;
            row_addr_q     <= row_addr_d;
            wb_idx_q       <= wb_idx_d;
            p_vld_q        <= p_vld_d;
            p_first_q      <= p_first_d;
            p_pos_q        <= p_pos_d;
            p_red_q        <= p_red_d;
            p_old_q        <= p_old_d;
            psum_ready_q   <= psum_ready_d;
            wb_en_q        <= wb_en_d;
            wb_addr_q      <= wb_addr_d;
            wb_data_q      <= wb_data_d;
            wb_valid_q     <= wb_valid_d;
            engine_ready_q <= engine_ready_d;
`ifdef PSUM_BIAS_EN
            bias_q         <= bias_d;
            ch_row_q       <= ch_row_d;
`endif
        end
    end

endmodule

// File: tb/tb_psum_accum_wb.sv
// Scoreboard bench for psum_accum_wb: expected words queued at stimulus time, popped on wb_valid.
module tb_psum_accum_wb;
    localparam int unsigned LANES = 16;
    localparam int unsigned DW    = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_valid = 1'b0;
    logic [15:0]         i_channel = '0;
    logic [15:0]         o_channel = '0;
    logic [7:0]          o_side = '0;
    logic [29:0]         result_start_addr = '0;
    logic                psum_valid = 1'b0;
    logic [LANES*DW-1:0] psum_data = '0;
    logic                psum_ready, wb_en, wb_valid, engine_ready;
    logic [29:0]         wb_addr;
    logic                wb_re = 1'b0;
    logic [DW-1:0]       wb_data;
`ifdef PSUM_BIAS_EN
    logic                bias_valid = 1'b0;
    logic [DW-1:0]       bias = '0;
`endif

    psum_accum_wb dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .i_channel(i_channel),
        .o_channel(o_channel), .o_side(o_side), .result_start_addr(result_start_addr),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(psum_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_re(wb_re), .wb_data(wb_data),
        .wb_valid(wb_valid), .engine_ready(engine_ready)
`ifdef PSUM_BIAS_EN
        , .bias_valid(bias_valid), .bias(bias)
`endif
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [45:0]      exp_q[$];
    logic             re_prev = 1'b0;
    int               cur_ich, cur_och, cur_oside, cur_mode;
    logic [29:0]      cur_base;
    logic signed [23:0] m_acc [128];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input logic signed [23:0] a);
        int v;
        v = int'(a);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    always @(posedge clk) re_prev <= wb_re;

    // Every delivered word must follow a read request and match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            logic [45:0] e;
            chk("re_to_valid", 32'(re_prev), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wb_data", 32'(wb_data), 32'(e[15:0]));
                chk("wb_addr", 32'(wb_addr), 32'(e[45:16]));
            end
        end
    end

    task automatic send(input logic [LANES*DW-1:0] v);
        int n = 0;
        psum_data  = v;
        psum_valid = 1'b1;
        while (!psum_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("psum_ready_timeout", 32'(psum_ready), 32'd1);
        @(posedge clk); #1;
        psum_valid = 1'b0;
    endtask

    task automatic feed_row(input int r);
        int g_cnt, nlast, red;
        logic [LANES*DW-1:0] v;
        logic [15:0] lv;
        g_cnt = (cur_ich + LANES - 1) / LANES;
        nlast = cur_ich - (g_cnt - 1) * LANES;
        for (int g = 0; g < g_cnt; g++) begin
            for (int p = 0; p < cur_oside; p++) begin
                red = 0;
                for (int l = 0; l < LANES; l++) begin
                    case (cur_mode)
                        0: lv = 16'd1;
                        1: lv = (g == 1 && l >= 4) ? 16'd5 : 16'd1;
                        2: lv = (l == 0) ? 16'(7 + g) : 16'd0;
                        3: lv = (r % 2 == 0) ? 16'h7FFF : 16'h8000;
                        default: lv = 16'($urandom_range(0, 8191)) - 16'd4096;
                    endcase
                    v[l*DW +: DW] = lv;
                    if (g != g_cnt - 1 || l < nlast) red = red + int'($signed(lv));
                end
                if (g == 0) m_acc[p] = 24'(red);
                else        m_acc[p] = m_acc[p] + 24'(red);
                send(v);
            end
        end
        for (int p = 0; p < cur_oside; p++)
            exp_q.push_back({30'(cur_base + 30'(r * cur_oside)), sat16(m_acc[p])});
    endtask

    task automatic wait_wb_en();
        int n = 0;
        while (!wb_en && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("wb_en_high", 32'(wb_en), 32'd1);
    endtask

    // Issues o_side+2 requests with the given spacing; the last two must be ignored
    task automatic drain_row(input int gap);
        wait_wb_en();
        for (int w = 0; w < cur_oside + 2; w++) begin
            wb_re = 1'b1;
            @(posedge clk); #1;
            wb_re = 1'b0;
            repeat (gap - 1) begin
                @(posedge clk); #1;
            end
        end
        chk("wb_en_low", 32'(wb_en), 32'd0);
    endtask

    task automatic start_layer(input int ich, input int och, input int oside, input int mode,
                               input logic [29:0] base);
        cur_ich = ich; cur_och = och; cur_oside = oside; cur_mode = mode; cur_base = base;
        i_channel = 16'(ich); o_channel = 16'(och); o_side = 8'(oside);
        result_start_addr = base;
        cfg_valid = 1'b1;
    endtask

    task automatic run_layer(input int ich, input int och, input int oside, input int mode,
                             input int gap, input logic [29:0] base);
        int n = 0;
        start_layer(ich, och, oside, mode, base);
        for (int r = 0; r < oside * och; r++) begin
            feed_row(r);
            drain_row(gap);
        end
        while (!engine_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("engine_ready_done", 32'(engine_ready), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("engine_ready_clear", 32'(engine_ready), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_psum_ready"}, 32'(psum_ready), 32'd0);
        chk({pfx, "_wb_en"}, 32'(wb_en), 32'd0);
        chk({pfx, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({pfx, "_engine_ready"}, 32'(engine_ready), 32'd0);
        chk({pfx, "_wb_addr"}, 32'(wb_addr), 32'd0);
        chk({pfx, "_wb_data"}, 32'(wb_data), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_layer(16, 1, 4, 0, 1, 30'h100);     // all ones: 16 per word
        run_layer(20, 1, 2, 1, 1, 30'h200);     // masked last group: 20 per word
        run_layer(48, 2, 1, 2, 1, 30'h300);     // o_side=1 back-to-back groups: 24
        run_layer(16, 2, 1, 3, 1, 30'h400);     // saturation high then low
        run_layer(40, 2, 4, 4, 3, 30'h500);     // random data, gapped reads, 8 rows

        // Reset in the middle of a writeback row
        start_layer(32, 1, 4, 4, 30'h600);
        feed_row(0);
        wait_wb_en();
        wb_re = 1'b1;
        @(posedge clk); #1;
        wb_re = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_outputs_zero("midwb_rst");
        cfg_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk_outputs_zero("midwb_rst_edge");
        rst = 1'b0;
        @(posedge clk); #1;
        run_layer(16, 1, 4, 0, 2, 30'h700);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
